// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multi-cycle multiply/divide unit.
// Build option: define MULDIV_DIV_EN to compile the divide datapath.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int ITER_COUNT   = MULDIV_WIDTH;

  // Low word reported for a divide by zero.
  localparam logic [MULDIV_WIDTH-1:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Bit 1 of the op code selects divide.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  // Bit 0 of the op code selects the unsigned variant.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the datapath and the mul/div unit.
// Handshake: the master raises start with op/a/b valid; the unit samples it only
// while idle, then holds busy high until (and including) the single-cycle done
// pulse. hi/lo/div_by_zero are valid from done and hold until the next done.
// start seen while busy is dropped, not queued.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring
// divide. A single 33-bit adder serves both modes (add for MUL, subtract for DIV).
// Build option: MULDIV_DIV_EN compiles the divide shift/trial/restore path.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               bit_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               bit_o
);

  logic [2*WIDTH-1:0] shifted;
  logic               sub;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;

`ifdef MULDIV_DIV_EN
  // Divide shifts {rem, quot} left before the trial subtract; multiply does not.
  assign shifted = div_mode_i ? {acc_i[2*WIDTH-2:0], 1'b0} : acc_i;
  assign sub     = div_mode_i;
`else
  logic unused_div_mode;
  logic unused_acc_lsb;
  assign unused_div_mode = div_mode_i;
  assign unused_acc_lsb  = acc_i[0];
  assign shifted         = acc_i;
  assign sub             = 1'b0;
`endif

  // Shared 33-bit adder: a - b is formed as a + ~b + 1.
  assign addend = sub ? ~{1'b0, operand_i} : (bit_i ? {1'b0, operand_i} : '0);
  assign sum    = {1'b0, shifted[2*WIDTH-1:WIDTH]} + addend + {{WIDTH{1'b0}}, sub};

  // Select the next accumulator; the quotient bit is returned on its own so the
  // caller merges it into the accumulator LSB.
  always_comb begin
    acc_o = {sum, shifted[WIDTH-1:1]};
    bit_o = 1'b0;
`ifdef MULDIV_DIV_EN
    if (div_mode_i) begin
      if (!sum[WIDTH]) begin
        acc_o = {sum[WIDTH-1:0], shifted[WIDTH-1:0]};
        bit_o = 1'b1;
      end else begin
        acc_o = shifted;
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle 32-bit signed/unsigned multiply and divide with a
// start/busy/done handshake, writing a 64-bit HI/LO result.
// Build option: MULDIV_DIV_EN enables DIV/DIVU; without it they finish at once
// with div_by_zero set as an illegal-op indication.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic    clock,
  input  logic    reset,
  muldiv_if.slave bus,
  output state_e  dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic               signed_op;
  logic               neg_res;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   step_operand;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_bit;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  // Operand magnitudes for the signed ops; the iterations work on unsigned values.
  always_comb begin
    signed_op = is_signed_op(op_q);
    mag_a     = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b     = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  // Multiply adds the multiplicand under the multiplier LSB; divide subtracts the divisor.
  assign step_operand = is_div_op(op_q) ? b_q : a_q;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_mode_i (is_div_op(op_q)),
    .acc_i      (acc_q),
    .operand_i  (step_operand),
    .bit_i      (b_q[0]),
    .acc_o      (step_acc),
    .bit_o      (step_bit)
  );

  assign acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_bit};

  // Sign fix-up of the raw unsigned result (product, or remainder/quotient).
  always_comb begin
    neg_res      = sign_a_q ^ sign_b_q;
    {hi_d, lo_d} = neg_res ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    if (is_div_op(op_q)) begin
      lo_d = neg_res  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= op_e'(bus.op);
            a_q    <= bus.a;
            b_q    <= bus.b;
            busy_q <= 1'b1;
            if (is_div_op(bus.op)) begin
`ifdef MULDIV_DIV_EN
              if (bus.b == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                hi_q    <= bus.a;
                lo_q    <= DIV0_LO[WIDTH-1:0];
                dbz_q   <= 1'b1;
              end else begin
                state_q <= ST_PREP;
              end
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hi_q    <= '0;
              lo_q    <= '0;
              dbz_q   <= 1'b1;
`endif
            end else begin
              state_q <= ST_PREP;
            end
          end
        end
        ST_PREP: begin
          sign_a_q <= signed_op & a_q[WIDTH-1];
          sign_b_q <= signed_op & b_q[WIDTH-1];
          a_q      <= mag_a;
          b_q      <= mag_b;
          // Divide starts with the dividend in the quotient half so it shifts into rem.
          acc_q    <= is_div_op(op_q) ? {{WIDTH{1'b0}}, mag_a} : '0;
          cnt_q    <= CNT_W'(WIDTH - 1);
          state_q  <= ST_ITER;
        end
        ST_ITER: begin
          acc_q <= acc_d;
          if (!is_div_op(op_q)) begin
            b_q <= b_q >> 1;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dbz_q   <= 1'b0;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized operations against an arithmetic
// reference model, covering latency, busy/done framing, result hold and reset abort.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;
  logic         prev_dbz;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] hi,
                                    output logic [W-1:0] lo, output logic dbz,
                                    output int lat);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    dbz = 1'b0;
    lat = W + 3;
    hi  = '0;
    lo  = '0;
    sa  = a;
    sb  = b;
    case (op)
      2'b00: begin
        sp       = longint'(sa) * longint'(sb);
        {hi, lo} = 64'(sp);
      end
      2'b01: begin
        up       = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 0) begin
          hi  = a;
          lo  = 32'hFFFF_FFFF;
          dbz = 1'b1;
          lat = 1;
        end else if (op == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'h0;
          end else begin
            lo = sa / sb;
            hi = sa % sb;
          end
        end else begin
          lo = a / b;
          hi = a % b;
        end
`else
        dbz = 1'b1;
        lat = 1;
`endif
      end
    endcase
  endfunction

  // Driver: issue one operation and check framing, latency and results.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit hold);
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_dbz;
    int           e_lat;
    int           lat;
    bit           busy_ok;
    ref_model(op, a, b, e_hi, e_lo, e_dbz, e_lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.a  = $urandom;
    bus.b  = $urandom;
    if (e_lat > 1) begin
      check("hold_hi", bus.hi, prev_hi);
      check("hold_lo", bus.lo, prev_lo);
      check("hold_dbz", bus.div_by_zero, prev_dbz);
    end
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("latency", lat, e_lat);
    check("busy_frame", busy_ok, 1'b1);
    check("hi", bus.hi, e_hi);
    check("lo", bus.lo, e_lo);
    check("div_by_zero", bus.div_by_zero, e_dbz);
    @(posedge clk);
    #1;
    check("done_pulse", bus.done, 1'b0);
    check("busy_clear", bus.busy, 1'b0);
    check("hi_held", bus.hi, e_hi);
    check("lo_held", bus.lo, e_lo);
    prev_hi  = e_hi;
    prev_lo  = e_lo;
    prev_dbz = e_dbz;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 9));
      3:       return -32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    prev_hi   = '0;
    prev_lo   = '0;
    prev_dbz  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(OP_MUL,  32'd7,          32'hFFFF_FFFD, 1'b0);
    run_op(OP_MULU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,         1'b0);
    run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIVU, 32'd100,        32'd0,         1'b0);
    run_op(OP_MULU, 32'd3,          32'd5,         1'b0);
    run_op(OP_MUL,  32'h8000_0000,  32'h8000_0000, 1'b1);
    run_op(OP_DIVU, 32'hFFFF_FFFF,  32'd7,         1'b1);
    run_op(OP_DIV,  32'd7,          32'hFFFF_FFFE, 1'b0);

    // Randomized operations, some back-to-back, some with idle gaps
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
             bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of an iteration
    run_op(OP_MULU, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULU;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);
    check("abort_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst      = 1'b0;
    prev_hi  = '0;
    prev_lo  = '0;
    prev_dbz = 1'b0;
    run_op(OP_MULU, 32'd2, 32'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
